// File: rtl/ucomb_arbiter.sv
// ----------------------------------------------------------------------------
// ucomb_arbiter
//
// Shares one combinational gate block among NREQ requesters. A requester is
// picked by round-robin, its 27-bit vector is held on ucomb_in for SETTLE
// cycles, and the gate's 6-bit result is then captured and returned with
// the requester's index. Only one transaction is in flight at a time.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   req_valid  [NREQ-1:0]     per-requester request pending
//   req_in     [NREQ*27-1:0]  requester i vector in bits [27i+26:27i]
//   req_ready  [NREQ-1:0]     one-hot accept pulse (grant cycle only)
//   ucomb_in   [26:0]         held vector driven to the shared gate block
//   ucomb_out  [5:0]          result returned by the shared gate block
//   rsp_valid  response available
//   rsp_ready  consumer accepts the response
//   rsp_id     [1:0]          requester the response belongs to
//   rsp_data   [5:0]          sampled gate result
//   busy       high in DRIVE and RESP
// ----------------------------------------------------------------------------
module ucomb_arbiter #(
   parameter int SETTLE = 2,   // 1..15
   parameter int NREQ   = 4    // fixed at 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*27-1:0]   req_in,
   output logic [NREQ-1:0]      req_ready,
   output logic [26:0]          ucomb_in,
   input  logic [5:0]           ucomb_out,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [1:0]           rsp_id,
   output logic [5:0]           rsp_data,
   output logic                 busy
);

   localparam int DW = 27;
   localparam int IW = $clog2(NREQ);
   localparam int CW = 4;

   typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

   state_t           state;
   logic [IW-1:0]    ptr;
   logic [CW-1:0]    cnt;
   logic             hold_off;   // blocks a grant in the first IDLE cycle after RESP

   // Per-requester vector slices
   logic [DW-1:0]    req_vec [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_slice
         assign req_vec[gi] = req_in[gi*DW +: DW];
      end
   endgenerate

   // Round-robin search starting at ptr. NREQ is a power of two, so the
   // IW-bit add wraps modulo NREQ on its own.
   logic [IW-1:0]    gnt_idx;
   logic [IW-1:0]    scan_idx;
   logic             gnt_hit;

   always_comb begin
      gnt_hit  = 1'b0;
      gnt_idx  = '0;
      scan_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = ptr + IW'(k);
         if (!gnt_hit && req_valid[scan_idx]) begin
            gnt_hit = 1'b1;
            gnt_idx = scan_idx;
         end
      end
   end

   // req_ready has to be visible in the same cycle the FSM sits in IDLE so
   // the requester sees its acceptance while it still holds req_valid; it is
   // therefore decoded from registered state rather than registered itself.
   // rst gates it so nothing is offered while reset is held.
   logic grant;
   assign grant     = (state == IDLE) && !hold_off && gnt_hit && !rst;
   assign req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         cnt       <= '0;
         hold_off  <= 1'b0;
         ucomb_in  <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               hold_off <= 1'b0;
               if (grant) begin
                  ucomb_in <= req_vec[gnt_idx];
                  rsp_id   <= gnt_idx;
                  ptr      <= gnt_idx + IW'(1);
                  cnt      <= CW'(SETTLE - 1);
                  state    <= DRIVE;
               end
            end
            DRIVE: begin
               // ucomb_in is left untouched here so the gate sees a stable input
               if (cnt == '0) begin
                  rsp_data  <= ucomb_out;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  hold_off  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
